ctrl_sequencer: RTL and testbench

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/ctrl_pkg.sv | 67 ++++++
 rtl/ctrl_decode.sv | 18 +
 rtl/ctrl_sequencer.sv | 148 ++++++++++++++
 tb/tb_ctrl_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types, opcode map and the pure single-cycle decode used by ctrl_sequencer.
// Opcodes are compared at a fixed 8-bit width so the decode stays independent of OPC_W.
package ctrl_pkg;

  localparam int OPC_EXT_W = 8;

  localparam logic [OPC_EXT_W-1:0] OPC_NOP   = 8'd0;
  localparam logic [OPC_EXT_W-1:0] OPC_ADD   = 8'd1;
  localparam logic [OPC_EXT_W-1:0] OPC_ADDI  = 8'd2;
  localparam logic [OPC_EXT_W-1:0] OPC_LOAD  = 8'd3;
  localparam logic [OPC_EXT_W-1:0] OPC_STORE = 8'd4;
  localparam logic [OPC_EXT_W-1:0] OPC_BEQ   = 8'd5;
  localparam logic [OPC_EXT_W-1:0] OPC_OUT   = 8'd6;
  localparam logic [OPC_EXT_W-1:0] OPC_IN    = 8'd7;
  localparam logic [OPC_EXT_W-1:0] OPC_PUSH  = 8'd8;
  localparam logic [OPC_EXT_W-1:0] OPC_CALL  = 8'd9;
  localparam logic [OPC_EXT_W-1:0] OPC_RET   = 8'd10;
  localparam logic [OPC_EXT_W-1:0] OPC_POP   = 8'd11;
  localparam logic [OPC_EXT_W-1:0] OPC_RETI  = 8'd14;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_PC,
    PUSH_FLG,
    POP_FLG,
    POP_PC,
    LOAD_PC
  } seq_state_t;

  typedef struct packed {
    logic alu_src;
    logic reg_write;
    logic memr;
    logic memw;
    logic mtr;
    logic branch;
    logic out;
    logic in;
    logic pushpop;
    logic spop;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [OPC_EXT_W-1:0] opc);
    ctrl_t c;
    c = '0;
    case (opc)
      OPC_ADD:   c.reg_write = 1'b1;
      OPC_ADDI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
      OPC_LOAD:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.memr = 1'b1; c.mtr = 1'b1; end
      OPC_STORE: begin c.alu_src = 1'b1; c.memw = 1'b1; end
      OPC_BEQ:   c.branch = 1'b1;
      OPC_OUT:   c.out = 1'b1;
      OPC_IN:    begin c.reg_write = 1'b1; c.in = 1'b1; end
      OPC_PUSH:  begin c.memw = 1'b1; c.pushpop = 1'b1; end
      OPC_POP:   begin
        c.reg_write = 1'b1; c.memr = 1'b1; c.mtr = 1'b1; c.pushpop = 1'b1; c.spop = 1'b1;
      end
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_seq_op(input logic [OPC_EXT_W-1:0] opc);
    return (opc == OPC_CALL) || (opc == OPC_RET) || (opc == OPC_RETI);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Single-cycle control decode; forced to zero while the sequencer holds the decode stage.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic             op_valid,
  input  logic             hold,
  output ctrl_t            ctrl
);

  logic [OPC_EXT_W-1:0] opc_ext;

  assign opc_ext = OPC_EXT_W'(opcode);
  assign ctrl    = (op_valid && !hold) ? decode_op(opc_ext) : '0;

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle CALL/RET/RETI/interrupt sequencer: pushes/pops the PC word by word,
// saves/restores flags and loads the PC, stalling fetch/decode meanwhile.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter  int OPC_W  = 4,
  parameter  int PC_W   = 32,
  parameter  int MEM_W  = 16,
  localparam int NWORDS = PC_W / MEM_W,
  localparam int WS_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             op_valid,
  input  logic             interrupt,
  output ctrl_t            ctrl,
  output logic             stall,
  output logic             seq_memw,
  output logic             seq_memr,
  output logic             sp_dec,
  output logic             sp_inc,
  output logic [WS_W-1:0]  word_sel,
  output logic             pc_load,
  output logic             pc_vec,
  output logic             flags_save,
  output logic             flags_restore,
  output logic             int_ack,
  output logic             busy
);

  localparam logic [WS_W-1:0] CNT_TOP = WS_W'(NWORDS - 1);

  seq_state_t           state_reg, state_next;
  logic [WS_W-1:0]      cnt_reg, cnt_next;
  logic                 is_int_reg, is_int_next;
  logic                 int_prev_reg, int_pend_reg, int_pend_next;
  logic [OPC_EXT_W-1:0] opc_ext;
  logic                 int_rise, int_req, seq_op, accept;
  logic                 seq_memw_reg, seq_memr_reg, pc_load_reg, pc_vec_reg;
  logic                 flags_save_reg, flags_restore_reg, busy_reg;

  assign opc_ext  = OPC_EXT_W'(opcode);
  assign int_rise = interrupt && !int_prev_reg;
  // A fresh edge counts in the same IDLE cycle so it beats a simultaneous sequencing opcode.
  assign int_req  = int_pend_reg || int_rise;
  assign seq_op   = op_valid && is_seq_op(opc_ext);
  assign accept   = (state_reg == IDLE) && (int_req || seq_op);

  assign stall         = rst_n && (busy_reg || accept);
  assign int_ack       = rst_n && (state_reg == IDLE) && int_req;
  assign seq_memw      = seq_memw_reg;
  assign sp_dec        = seq_memw_reg;
  assign seq_memr      = seq_memr_reg;
  assign sp_inc        = seq_memr_reg;
  assign word_sel      = cnt_reg;
  assign pc_load       = pc_load_reg;
  assign pc_vec        = pc_vec_reg;
  assign flags_save    = flags_save_reg;
  assign flags_restore = flags_restore_reg;
  assign busy          = busy_reg;

  ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .opcode   (opcode),
    .op_valid (op_valid),
    .hold     (stall || !rst_n),
    .ctrl     (ctrl)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    is_int_next   = is_int_reg;
    int_pend_next = (state_reg == IDLE) ? 1'b0 : (int_pend_reg || int_rise);
    case (state_reg)
      IDLE: begin
        if (int_req) begin
          state_next  = PUSH_PC;
          cnt_next    = CNT_TOP;
          is_int_next = 1'b1;
        end else if (op_valid && opc_ext == OPC_CALL) begin
          state_next  = PUSH_PC;
          cnt_next    = CNT_TOP;
          is_int_next = 1'b0;
        end else if (op_valid && opc_ext == OPC_RET) begin
          state_next = POP_PC;
          cnt_next   = '0;
        end else if (op_valid && opc_ext == OPC_RETI) begin
          state_next = POP_FLG;
        end
      end
      PUSH_PC: begin
        if (cnt_reg == '0) state_next = is_int_reg ? PUSH_FLG : LOAD_PC;
        else               cnt_next   = cnt_reg - WS_W'(1);
      end
      PUSH_FLG: state_next = LOAD_PC;
      POP_FLG: begin
        state_next = POP_PC;
        cnt_next   = '0;
      end
      POP_PC: begin
        if (cnt_reg == CNT_TOP) begin
          state_next = LOAD_PC;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + WS_W'(1);
        end
      end
      LOAD_PC: begin
        state_next  = IDLE;
        is_int_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      is_int_reg        <= 1'b0;
      int_prev_reg      <= 1'b0;
      int_pend_reg      <= 1'b0;
      seq_memw_reg      <= 1'b0;
      seq_memr_reg      <= 1'b0;
      pc_load_reg       <= 1'b0;
      pc_vec_reg        <= 1'b0;
      flags_save_reg    <= 1'b0;
      flags_restore_reg <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      is_int_reg        <= is_int_next;
      int_prev_reg      <= interrupt;
      int_pend_reg      <= int_pend_next;
      seq_memw_reg      <= (state_next == PUSH_PC) || (state_next == PUSH_FLG);
      seq_memr_reg      <= (state_next == POP_FLG) || (state_next == POP_PC);
      pc_load_reg       <= (state_next == LOAD_PC);
      pc_vec_reg        <= (state_reg == PUSH_FLG);
      flags_save_reg    <= (state_next == PUSH_FLG);
      flags_restore_reg <= (state_next == POP_FLG);
      busy_reg          <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed cycle-by-cycle bench for ctrl_sequencer: a 32/16 instance plus a 16/16 instance.
module tb_ctrl_sequencer;
  import ctrl_pkg::*;

  localparam logic [11:0] S   = 12'h800;
  localparam logic [11:0] W   = 12'h400;
  localparam logic [11:0] R   = 12'h200;
  localparam logic [11:0] DEC = 12'h100;
  localparam logic [11:0] INC = 12'h080;
  localparam logic [11:0] WS  = 12'h040;
  localparam logic [11:0] LD  = 12'h020;
  localparam logic [11:0] VEC = 12'h010;
  localparam logic [11:0] FS  = 12'h008;
  localparam logic [11:0] FR  = 12'h004;
  localparam logic [11:0] ACK = 12'h002;
  localparam logic [11:0] BSY = 12'h001;

  localparam logic [3:0] T_ADD  = 4'd1;
  localparam logic [3:0] T_LOAD = 4'd3;
  localparam logic [3:0] T_CALL = 4'b1001;
  localparam logic [3:0] T_RET  = 4'b1010;
  localparam logic [3:0] T_POP  = 4'b1011;
  localparam logic [3:0] T_RETI = 4'b1110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       op_valid = 1'b0;
  logic       interrupt = 1'b0;

  ctrl_t ctrl_a, ctrl_b;
  logic  stall_a, memw_a, memr_a, dec_a, inc_a, ws_a, ld_a, vec_a, fs_a, fr_a, ack_a, busy_a;
  logic  stall_b, memw_b, memr_b, dec_b, inc_b, ws_b, ld_b, vec_b, fs_b, fr_b, ack_b, busy_b;
  logic [11:0] obs_a, obs_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ctrl_sequencer #(.OPC_W(4), .PC_W(32), .MEM_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .op_valid(op_valid), .interrupt(interrupt),
    .ctrl(ctrl_a), .stall(stall_a), .seq_memw(memw_a), .seq_memr(memr_a),
    .sp_dec(dec_a), .sp_inc(inc_a), .word_sel(ws_a), .pc_load(ld_a), .pc_vec(vec_a),
    .flags_save(fs_a), .flags_restore(fr_a), .int_ack(ack_a), .busy(busy_a)
  );

  ctrl_sequencer #(.OPC_W(4), .PC_W(16), .MEM_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .op_valid(op_valid), .interrupt(interrupt),
    .ctrl(ctrl_b), .stall(stall_b), .seq_memw(memw_b), .seq_memr(memr_b),
    .sp_dec(dec_b), .sp_inc(inc_b), .word_sel(ws_b), .pc_load(ld_b), .pc_vec(vec_b),
    .flags_save(fs_b), .flags_restore(fr_b), .int_ack(ack_b), .busy(busy_b)
  );

  assign obs_a = {stall_a, memw_a, memr_a, dec_a, inc_a, ws_a, ld_a, vec_a, fs_a, fr_a, ack_a, busy_a};
  assign obs_b = {stall_b, memw_b, memr_b, dec_b, inc_b, ws_b, ld_b, vec_b, fs_b, fr_b, ack_b, busy_b};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [11:0] exp_a);
    @(negedge clk);
    check(tag, {4'b0, obs_a}, {4'b0, exp_a});
    @(posedge clk); #1;
  endtask

  task automatic cyc2(input string tag, input logic [11:0] exp_a, input logic [11:0] exp_b);
    @(negedge clk);
    check({tag, "_a"}, {4'b0, obs_a}, {4'b0, exp_a});
    check({tag, "_b"}, {4'b0, obs_b}, {4'b0, exp_b});
    @(posedge clk); #1;
  endtask

  task automatic cycc(input string tag, input logic [11:0] exp_a, input logic [9:0] exp_ctrl);
    @(negedge clk);
    check(tag, {4'b0, obs_a}, {4'b0, exp_a});
    check({tag, "_ctrl"}, {6'b0, ctrl_a}, {6'b0, exp_ctrl});
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset held with a CALL and interrupt present: everything must stay quiet.
    opcode = T_CALL; op_valid = 1'b1; interrupt = 1'b1;
    #3;
    check("rst_obs_a", {4'b0, obs_a}, 16'h0);
    check("rst_obs_b", {4'b0, obs_b}, 16'h0);
    check("rst_ctrl", {6'b0, ctrl_a}, 16'h0);
    @(posedge clk); #1;
    check("rst_obs_clk", {4'b0, obs_a}, 16'h0);
    rst_n = 1'b1; op_valid = 1'b0; interrupt = 1'b0; opcode = T_ADD;
    cyc2("idle_after_rst", 12'h0, 12'h0);
    $display("txn reset done");

    op_valid = 1'b1; opcode = T_ADD;  cycc("dec_add", 12'h0, 10'h100);
    opcode = T_LOAD;                  cycc("dec_load", 12'h0, 10'h3A0);
    opcode = T_POP;                   cycc("dec_pop", 12'h0, 10'h1A3);
    op_valid = 1'b0;                  cycc("dec_invalid", 12'h0, 10'h000);
    $display("txn decode done");

    opcode = T_CALL; op_valid = 1'b1;
    cycc("call_accept", S, 10'h0);
    opcode = T_ADD;
    cycc("call_push_hi", S | W | DEC | WS | BSY, 10'h0);
    cyc("call_push_lo", S | W | DEC | BSY);
    cyc("call_load", S | LD | BSY);
    cycc("call_idle", 12'h0, 10'h100);
    op_valid = 1'b0;
    $display("txn CALL done");

    opcode = T_RETI; op_valid = 1'b1;
    cyc("reti_accept", S);
    op_valid = 1'b0;
    cyc("reti_pop_flg", S | R | INC | FR | BSY);
    cyc("reti_pop_w0", S | R | INC | BSY);
    cyc("reti_pop_w1", S | R | INC | WS | BSY);
    cyc("reti_load", S | LD | BSY);
    cyc("reti_idle", 12'h0);
    $display("txn RETI done");

    opcode = T_RET; op_valid = 1'b1;
    cyc2("ret_accept", S, S);
    op_valid = 1'b0;
    cyc2("ret_c1", S | R | INC | BSY, S | R | INC | BSY);
    cyc2("ret_c2", S | R | INC | WS | BSY, S | LD | BSY);
    cyc2("ret_c3", S | LD | BSY, 12'h0);
    cyc2("ret_idle", 12'h0, 12'h0);
    $display("txn RET done");

    opcode = T_RET; op_valid = 1'b1; interrupt = 1'b1;
    cyc("irq_ack", S | ACK);
    interrupt = 1'b0;
    cyc("irq_push_hi", S | W | DEC | WS | BSY);
    cyc("irq_push_lo", S | W | DEC | BSY);
    cyc("irq_push_flg", S | W | DEC | FS | BSY);
    cyc("irq_load_vec", S | LD | VEC | BSY);
    cyc("irq_ret_accept", S);
    op_valid = 1'b0;
    cyc("irq_ret_w0", S | R | INC | BSY);
    cyc("irq_ret_w1", S | R | INC | WS | BSY);
    cyc("irq_ret_load", S | LD | BSY);
    cyc("irq_ret_idle", 12'h0);
    $display("txn IRQ+RET done");

    opcode = T_CALL; op_valid = 1'b1;
    cyc("merge_accept", S);
    op_valid = 1'b0; interrupt = 1'b1;
    cyc("merge_push_hi", S | W | DEC | WS | BSY);
    interrupt = 1'b0;
    cyc("merge_push_lo", S | W | DEC | BSY);
    interrupt = 1'b1;
    cyc("merge_load_noack", S | LD | BSY);
    interrupt = 1'b0;
    cyc("merge_ack", S | ACK);
    cyc("merge_irq_hi", S | W | DEC | WS | BSY);
    cyc("merge_irq_lo", S | W | DEC | BSY);
    cyc("merge_irq_flg", S | W | DEC | FS | BSY);
    cyc("merge_irq_load", S | LD | VEC | BSY);
    cyc("merge_no_second_ack", 12'h0);
    $display("txn IRQ merge done");

    opcode = T_CALL; op_valid = 1'b1;
    cyc("abort_accept", S);
    op_valid = 1'b0;
    cyc("abort_push_hi", S | W | DEC | WS | BSY);
    check("abort_push_lo", {4'b0, obs_a}, {4'b0, S | W | DEC | BSY});
    rst_n = 1'b0;
    #1;
    check("abort_async_zero", {4'b0, obs_a}, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("abort_idle", 12'h0);
    opcode = T_CALL; op_valid = 1'b1;
    cyc("abort_recall_accept", S);
    op_valid = 1'b0;
    cyc("abort_recall_hi", S | W | DEC | WS | BSY);
    cyc("abort_recall_lo", S | W | DEC | BSY);
    cyc("abort_recall_load", S | LD | BSY);
    cyc("abort_recall_idle", 12'h0);
    $display("txn reset abort done");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
